// File: rtl/stim_seq_param_if.sv
// Control/status bundle for the biphasic stimulation sequencer.
// The master side supplies the run request and the pulse-train configuration.
// The slave side (the sequencer) returns the driver controls and the status.
interface stim_seq_param_if #(
  parameter int CH_W  = 3,
  parameter int MAG_W = 5,
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [CNT_W-1:0] rest_cyc_i;
  logic [CNT_W-1:0] ano_cyc_i;
  logic [CNT_W-1:0] ipd_cyc_i;
  logic [CNT_W-1:0] cat_cyc_i;
  logic [MAG_W-1:0] mag_tgt_i;
  logic             ramp_en_i;
  logic             sweep_en_i;
  logic [CH_W-1:0]  ch_ano_i;
  logic [CH_W-1:0]  ch_cat_i;

  logic             en_st_o;
  logic [MAG_W-1:0] mag_st_o;
  logic [CH_W-1:0]  chsel_hs_o;
  logic [CH_W-1:0]  chsel_ls_o;
  logic             busy_o;
  logic             pulse_done_o;

  modport master (
    output start_i, rest_cyc_i, ano_cyc_i, ipd_cyc_i, cat_cyc_i,
    output mag_tgt_i, ramp_en_i, sweep_en_i, ch_ano_i, ch_cat_i,
    input  en_st_o, mag_st_o, chsel_hs_o, chsel_ls_o, busy_o, pulse_done_o
  );

  modport slave (
    input  start_i, rest_cyc_i, ano_cyc_i, ipd_cyc_i, cat_cyc_i,
    input  mag_tgt_i, ramp_en_i, sweep_en_i, ch_ano_i, ch_cat_i,
    output en_st_o, mag_st_o, chsel_hs_o, chsel_ls_o, busy_o, pulse_done_o
  );
endinterface

// File: rtl/stim_seq_param.sv
// Biphasic stimulation pulse-train sequencer.
//
//   state | meaning
//   IDLE  | waiting for a run request; configuration is latched on exit
//   REST  | inter-train rest, driver off; dropping the run request aborts here
//   ANO   | anodic phase, driver on, HS=anode LS=cathode
//   IPD   | inter-phase delay, driver off
//   CAT   | cathodic phase, driver on, HS=cathode LS=anode; last cycle strobes done
//
// Each phase lasts max(duration,1) cycles. The phase counter loads the duration
// and the phase ends when it reaches 1 (or is 0), so the all-ones value never
// needs an extra bit. All outputs come straight from flops whose next value is
// derived from the next state, so they line up with the state they describe.
module stim_seq_param #(
  parameter int N_CH  = 8,
  parameter int CH_W  = 3,
  parameter int MAG_W = 5,
  parameter int CNT_W = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  stim_seq_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REST = 3'd1,
    S_ANO  = 3'd2,
    S_IPD  = 3'd3,
    S_CAT  = 3'd4
  } state_e;

  localparam logic [CH_W-1:0] K_LAST = CH_W'(N_CH / 2 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  k_q, k_d;
  logic [MAG_W-1:0] mag_q, mag_d;

  logic [CNT_W-1:0] rest_q, ano_q, ipd_q, cat_q;
  logic [MAG_W-1:0] tgt_q;
  logic             ramp_q, sweep_q;
  logic [CH_W-1:0]  cha_q, chc_q;

  logic             en_q, en_d;
  logic [CH_W-1:0]  hs_q, hs_d;
  logic [CH_W-1:0]  ls_q, ls_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last;
  logic             wrap;
  logic [CNT_W-1:0] cnt_dec;
  logic [CH_W-1:0]  pair_ano, pair_cat;

  assign last    = (cnt_q <= CNT_W'(1));
  assign wrap    = (k_q == K_LAST);
  assign cnt_dec = cnt_q - CNT_W'(1);

  // Next state, phase counter, sweep index and magnitude.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    mag_d   = mag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_REST;
          cnt_d   = bus.rest_cyc_i;
          k_d     = '0;
          mag_d   = bus.ramp_en_i ? '0 : bus.mag_tgt_i;
        end
      end
      S_REST: begin
        if (!bus.start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = S_ANO;
          cnt_d   = ano_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_ANO: begin
        if (last) begin
          state_d = S_IPD;
          cnt_d   = ipd_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_IPD: begin
        if (last) begin
          state_d = S_CAT;
          cnt_d   = cat_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_CAT: begin
        if (last) begin
          // Pulse boundary: the only place the channel pair and magnitude move.
          if (sweep_q) begin
            k_d = wrap ? '0 : k_q + CH_W'(1);
          end
          if (ramp_q && (!sweep_q || wrap) && (mag_q < tgt_q)) begin
            mag_d = mag_q + MAG_W'(1);
          end
          if (bus.start_i) begin
            state_d = S_REST;
            cnt_d   = rest_q;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Driver controls and status for the upcoming state.
  always_comb begin
    pair_ano = sweep_q ? CH_W'({k_d, 1'b0}) : cha_q;
    pair_cat = sweep_q ? (CH_W'({k_d, 1'b0}) | CH_W'(1)) : chc_q;
    en_d     = (state_d == S_ANO) || (state_d == S_CAT);
    hs_d     = '0;
    ls_d     = '0;
    if (state_d == S_ANO) begin
      hs_d = pair_ano;
      ls_d = pair_cat;
    end else if (state_d == S_CAT) begin
      hs_d = pair_cat;
      ls_d = pair_ano;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_CAT) && (cnt_d <= CNT_W'(1));
  end

  // Sequencer state, configuration latch and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      mag_q   <= '0;
      rest_q  <= '0;
      ano_q   <= '0;
      ipd_q   <= '0;
      cat_q   <= '0;
      tgt_q   <= '0;
      ramp_q  <= 1'b0;
      sweep_q <= 1'b0;
      cha_q   <= '0;
      chc_q   <= '0;
      en_q    <= 1'b0;
      hs_q    <= '0;
      ls_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.start_i) begin
        rest_q  <= bus.rest_cyc_i;
        ano_q   <= bus.ano_cyc_i;
        ipd_q   <= bus.ipd_cyc_i;
        cat_q   <= bus.cat_cyc_i;
        tgt_q   <= bus.mag_tgt_i;
        ramp_q  <= bus.ramp_en_i;
        sweep_q <= bus.sweep_en_i;
        cha_q   <= bus.ch_ano_i;
        chc_q   <= bus.ch_cat_i;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      mag_q   <= mag_d;
      en_q    <= en_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.en_st_o      = en_q;
  assign bus.mag_st_o     = mag_q;
  assign bus.chsel_hs_o   = hs_q;
  assign bus.chsel_ls_o   = ls_q;
  assign bus.busy_o       = busy_q;
  assign bus.pulse_done_o = done_q;

endmodule

// File: tb/tb_stim_seq_param.sv
// Testbench for stim_seq_param: a phase-queue reference model checked every
// cycle, plus hand-computed waveform expectations for the directed scenarios.
module tb_stim_seq_param;
  localparam int N_CH  = 8;
  localparam int CH_W  = 3;
  localparam int MAG_W = 5;
  localparam int CNT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stim_seq_param_if #(.CH_W(CH_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) bus ();

  stim_seq_param #(.N_CH(N_CH), .CH_W(CH_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // One record per expected clock cycle; a whole pulse is queued at its start.
  typedef struct {
    int ph;   // 0 idle, 1 rest, 2 anodic, 3 inter-phase, 4 cathodic
    int en;
    int hs;
    int ls;
    int done;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int m_rest, m_ano, m_ipd, m_cat, m_tgt, m_ramp, m_sweep, m_cha, m_chc;
  int m_k, m_mag;

  function automatic rec_t mk(int ph, int en, int hs, int ls, int done);
    rec_t r;
    r.ph = ph; r.en = en; r.hs = hs; r.ls = ls; r.done = done;
    return r;
  endfunction

  function automatic int dur(int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void build_pulse();
    int a, c;
    a = m_sweep ? 2 * m_k : m_cha;
    c = m_sweep ? 2 * m_k + 1 : m_chc;
    for (int i = 0; i < dur(m_rest); i++) q.push_back(mk(1, 0, 0, 0, 0));
    for (int i = 0; i < dur(m_ano); i++)  q.push_back(mk(2, 1, a, c, 0));
    for (int i = 0; i < dur(m_ipd); i++)  q.push_back(mk(3, 0, 0, 0, 0));
    for (int i = 0; i < dur(m_cat); i++)
      q.push_back(mk(4, 1, c, a, (i == dur(m_cat) - 1) ? 1 : 0));
  endfunction

  function automatic void model_reset();
    q.delete();
    cur   = mk(0, 0, 0, 0, 0);
    m_k   = 0;
    m_mag = 0;
  endfunction

  function automatic void model_step(int start);
    if (cur.ph == 0) begin
      if (start != 0) begin
        m_rest  = int'(bus.rest_cyc_i);
        m_ano   = int'(bus.ano_cyc_i);
        m_ipd   = int'(bus.ipd_cyc_i);
        m_cat   = int'(bus.cat_cyc_i);
        m_tgt   = int'(bus.mag_tgt_i);
        m_ramp  = int'(bus.ramp_en_i);
        m_sweep = int'(bus.sweep_en_i);
        m_cha   = int'(bus.ch_ano_i);
        m_chc   = int'(bus.ch_cat_i);
        m_k     = 0;
        m_mag   = m_ramp ? 0 : m_tgt;
        build_pulse();
        cur = q.pop_front();
      end
    end else if (cur.ph == 1 && start == 0) begin
      q.delete();
      cur = mk(0, 0, 0, 0, 0);
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      bit wrapped;
      wrapped = (m_k == N_CH / 2 - 1);
      if (m_sweep) m_k = wrapped ? 0 : m_k + 1;
      if (m_ramp && (!m_sweep || wrapped) && m_mag < m_tgt) m_mag++;
      if (start != 0) begin
        build_pulse();
        cur = q.pop_front();
      end else begin
        cur = mk(0, 0, 0, 0, 0);
      end
    end
  endfunction

  // Model update at each edge, full output comparison just after it.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(int'(bus.start_i));
      #1;
      chk("m_en",   int'(bus.en_st_o),      cur.en);
      chk("m_hs",   int'(bus.chsel_hs_o),   cur.hs);
      chk("m_ls",   int'(bus.chsel_ls_o),   cur.ls);
      chk("m_busy", int'(bus.busy_o),       (cur.ph != 0) ? 1 : 0);
      chk("m_done", int'(bus.pulse_done_o), cur.done);
      chk("m_mag",  int'(bus.mag_st_o),     m_mag);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input int rest, input int ano, input int ipd, input int cat,
                         input int tgt, input int ramp, input int sweep,
                         input int cha, input int chc);
    bus.rest_cyc_i = CNT_W'(rest);
    bus.ano_cyc_i  = CNT_W'(ano);
    bus.ipd_cyc_i  = CNT_W'(ipd);
    bus.cat_cyc_i  = CNT_W'(cat);
    bus.mag_tgt_i  = MAG_W'(tgt);
    bus.ramp_en_i  = ramp[0];
    bus.sweep_en_i = sweep[0];
    bus.ch_ano_i   = CH_W'(cha);
    bus.ch_cat_i   = CH_W'(chc);
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_idle();
    int n;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", int'(bus.busy_o), 0);
  endtask

  int en_p[12]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
  int hs_p[12]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 2, 2, 2};
  int ls_p[12]  = '{0, 0, 0, 0, 2, 2, 2, 0, 0, 1, 1, 1};
  int dn_p[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int sw_a[5]   = '{0, 2, 4, 6, 0};
  int sw_c[5]   = '{1, 3, 5, 7, 1};
  int rmp_p[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2};

  initial begin
    int n, d, got, seen_en;
    bus.start_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_en",   int'(bus.en_st_o), 0);
    chk("rst_mag",  int'(bus.mag_st_o), 0);
    rst_n = 1'b1;
    cyc(5);
    chk("idle_wait_start", int'(bus.busy_o), 0);

    // Fixed pair, 12-cycle period, two full periods.
    set_cfg(4, 3, 2, 3, 31, 0, 0, 1, 2);
    bus.start_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #2;
      chk("fix_en",   int'(bus.en_st_o),      en_p[i % 12]);
      chk("fix_hs",   int'(bus.chsel_hs_o),   hs_p[i % 12]);
      chk("fix_ls",   int'(bus.chsel_ls_o),   ls_p[i % 12]);
      chk("fix_done", int'(bus.pulse_done_o), dn_p[i % 12]);
      chk("fix_mag",  int'(bus.mag_st_o),     31);
    end
    go_idle();

    // Channel sweep: five pulses walk the even/odd pairs and wrap.
    set_cfg(0, 1, 0, 1, 7, 0, 1, 3, 3);
    @(negedge clk);
    bus.start_i = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 5; i++) begin
      @(negedge clk);
      if (bus.pulse_done_o) begin
        chk("sweep_anode",   int'(bus.chsel_ls_o), sw_a[got]);
        chk("sweep_cathode", int'(bus.chsel_hs_o), sw_c[got]);
        got++;
      end
    end
    chk("sweep_pulses", got, 5);
    go_idle();

    // Ramp with sweep: magnitude steps once per full sweep, saturating at 2.
    set_cfg(0, 0, 0, 0, 2, 1, 1, 0, 0);
    @(negedge clk);
    bus.start_i = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && got < 16; i++) begin
      @(negedge clk);
      if (bus.pulse_done_o) begin
        chk("ramp_mag", int'(bus.mag_st_o), rmp_p[got]);
        got++;
      end
    end
    chk("ramp_pulses", got, 16);
    go_idle();

    // Zero durations: one cycle per phase, four-cycle period.
    set_cfg(0, 0, 0, 0, 5, 0, 0, 3, 4);
    @(negedge clk);
    bus.start_i = 1'b1;
    n = 0;
    while (!bus.pulse_done_o && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.pulse_done_o && n < 50);
    chk("zero_period", n, 4);
    go_idle();

    // Stop requested in the first anodic cycle: the pulse completes.
    set_cfg(2, 3, 2, 3, 9, 0, 0, 0, 7);
    @(negedge clk);
    bus.start_i = 1'b1;
    n = 0;
    while (!bus.en_st_o && n < 50) begin @(negedge clk); n++; end
    bus.start_i = 1'b0;
    n = 0;
    d = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.pulse_done_o) d++;
    end while (bus.busy_o && n < 50);
    chk("stop_ano_len",  n, 8);
    chk("stop_ano_done", d, 1);

    // Stop requested during rest: abort at the next edge, driver never enabled.
    set_cfg(5, 1, 1, 1, 9, 0, 0, 2, 3);
    @(negedge clk);
    bus.start_i = 1'b1;
    seen_en = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.en_st_o) seen_en = 1;
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_rest_busy", int'(bus.busy_o), 0);
    chk("stop_rest_en",   seen_en | int'(bus.en_st_o), 0);

    // Maximum duration loads cleanly and holds the rest phase.
    set_cfg(65535, 1, 1, 1, 3, 0, 0, 1, 2);
    @(negedge clk);
    bus.start_i = 1'b1;
    cyc(20);
    chk("max_rest_busy", int'(bus.busy_o), 1);
    go_idle();

    // Reset in the cathodic phase clears outputs with no clock edge.
    set_cfg(1, 2, 1, 3, 9, 0, 0, 5, 6);
    @(negedge clk);
    bus.start_i = 1'b1;
    n = 0;
    while (!(bus.en_st_o && bus.chsel_hs_o == 3'd6) && n < 50) begin @(negedge clk); n++; end
    chk("reach_cat", int'(bus.chsel_hs_o), 6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_cat_en",   int'(bus.en_st_o),    0);
    chk("rst_cat_hs",   int'(bus.chsel_hs_o), 0);
    chk("rst_cat_ls",   int'(bus.chsel_ls_o), 0);
    chk("rst_cat_busy", int'(bus.busy_o),     0);
    chk("rst_cat_mag",  int'(bus.mag_st_o),   0);
    bus.start_i = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", int'(bus.busy_o), 0);
    end
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_start", int'(bus.busy_o), 1);
    go_idle();

    // Random trains; configuration is scrambled while busy to show it is ignored.
    for (int t = 0; t < 40; t++) begin
      rand_cfg();
      @(negedge clk);
      bus.start_i = 1'b1;
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        rand_cfg();
        bus.start_i = ($urandom_range(0, 11) != 0);
        if (t % 13 == 5 && i == n / 2) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      go_idle();
      cyc($urandom_range(0, 3));
    end

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
